// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable simple dual-port RAM and its clear engine.
package ram_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 16;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/ram_clr_fsm.sv
// Sequential clear engine: walks the array writing zeros, then pulses done for one cycle.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr_req,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  localparam clr_state_e            LP_RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST      = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LP_RST_STATE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_d = CLEAR;
          w_ptr_d   = '0;
        end
      end
      CLEAR: begin
        w_ptr_d = r_ptr + 1'b1;
        if (r_ptr == LP_LAST) w_state_d = DONE;
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  assign o_clr_busy = (r_state == CLEAR);
  assign o_clr_done = (r_state == DONE);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write behaviour, out-of-range protection and a sequential clear engine.
module sdp_ram_be
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_din,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_dout,
  output logic                         rd_valid,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic                         acc_drop
);

  localparam int unsigned         LP_NBYTES    = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);
  localparam bit                  LP_WR_FIRST  = (RDW_MODE == 32'(RDW_WRITE_FIRST));

  if (DATA_WIDTH % BYTE_W != 0) begin : g_err_dw
    $fatal(1, "sdp_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_err_depth
    $fatal(1, "sdp_ram_be: DEPTH exceeds 2**ADDR_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_lat
    $fatal(1, "sdp_ram_be: RD_LATENCY must be 1 or 2");
  end

  logic                  w_clr_busy, w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_en, w_rd_en, w_rd_in_range, w_rdw_hit;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_vld;
  logic                  r_acc_drop;

  ram_clr_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH),
    .CLR_ON_RESET(CLR_ON_RESET)
  ) u_clr_fsm (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr_req (clr_req),
    .o_clr_busy(w_clr_busy),
    .o_clr_done(clr_done),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr)
  );

  assign clr_busy      = w_clr_busy;
  assign w_wr_en       = we && !w_clr_busy && ({1'b0, wr_addr} < LP_DEPTH_CMP);
  assign w_rd_en       = re && !w_clr_busy;
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH_CMP);
  assign w_rdw_hit     = LP_WR_FIRST && w_wr_en && w_rd_in_range && (wr_addr == rd_addr);

  // No reset on the array so it can map to block RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < LP_NBYTES; i++) begin
        if (wr_be[i]) r_mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    w_rd_word = w_rd_in_range ? r_mem[rd_addr] : '0;
    if (w_rdw_hit) begin
      for (int i = 0; i < LP_NBYTES; i++) begin
        if (wr_be[i]) w_rd_word[i*BYTE_W +: BYTE_W] = wr_din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_vld   <= 1'b0;
      r_acc_drop <= 1'b0;
    end else begin
      r_s1_vld   <= w_rd_en;
      r_acc_drop <= w_clr_busy && (we || re);
      if (w_rd_en) r_s1_data <= w_rd_word;
    end
  end

  assign acc_drop = r_acc_drop;

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_data <= '0;
        r_s2_vld  <= 1'b0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2_data <= r_s1_data;
      end
    end

    assign rd_dout  = r_s2_data;
    assign rd_valid = r_s2_vld;
  end else begin : g_lat1
    assign rd_dout  = r_s1_data;
    assign rd_valid = r_s1_vld;
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench: three RAM variants share one stimulus stream (a: lat1/read-first/16,
// b: lat2/write-first/16, c: lat1/read-first/12).
module tb_sdp_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re, clr_req;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_din;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        drop_a, drop_b, drop_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_a [16];
  logic [31:0] exp_c [12];

  always #5 clk = ~clk;

  sdp_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(1), .RDW_MODE(0), .CLR_ON_RESET(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_a), .rd_valid(valid_a), .clr_req(clr_req),
    .clr_busy(busy_a), .clr_done(done_a), .acc_drop(drop_a)
  );

  sdp_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(2), .RDW_MODE(1), .CLR_ON_RESET(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_b), .rd_valid(valid_b), .clr_req(clr_req),
    .clr_busy(busy_b), .clr_done(done_b), .acc_drop(drop_b)
  );

  sdp_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .RD_LATENCY(1), .RDW_MODE(0), .CLR_ON_RESET(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_c), .rd_valid(valid_c), .clr_req(clr_req),
    .clr_busy(busy_c), .clr_done(done_c), .acc_drop(drop_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; wr_addr = a; wr_din = d; wr_be = be;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    int busy_n_a = 0, busy_n_c = 0, done_n_a = 0, done_n_c = 0;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if (dout_a !== 32'h0 || valid_a !== 1'b0 || dout_b !== 32'h0 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read: a=%h/%b b=%h/%b, required 0/0", dout_a, valid_a, dout_b, valid_b);
    end
    n_tests++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || drop_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clr: busy=%b done=%b drop=%b, required 1 0 0", busy_a, done_a, drop_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy_a) busy_n_a++;
      if (busy_c) busy_n_c++;
      if (done_a) done_n_a++;
      if (done_c) done_n_c++;
      tick();
    end
    n_tests++;
    if (busy_n_a != 16 || done_n_a != 1) begin
      n_fail++;
      $display("FAIL por_clear_a: busy=%0d done=%0d, required 16 1", busy_n_a, done_n_a);
    end
    n_tests++;
    if (busy_n_c != 12 || done_n_c != 1) begin
      n_fail++;
      $display("FAIL por_clear_c: busy=%0d done=%0d, required 12 1", busy_n_c, done_n_c);
    end
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; rd_addr = 4'(i);
      tick();
      re = 1'b0;
      n_tests++;
      if (dout_a !== 32'h0 || valid_a !== 1'b1) begin
        n_fail++;
        $display("FAIL cleared_read[%0d]: got %h/%b, required 00000000/1", i, dout_a, valid_a);
      end
    end
    tick();
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
    exp_a[3] = 32'hAA22CC44; exp_c[3] = 32'hAA22CC44;
    re = 1'b1; rd_addr = 4'd3;
    tick();
    re = 1'b0;
    n_tests++;
    if (valid_a !== 1'b1 || dout_a !== 32'hAA22CC44 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL be_lat1: a=%h/%b b_valid=%b, required AA22CC44/1 0", dout_a, valid_a,
               valid_b);
    end
    tick();
    n_tests++;
    if (valid_b !== 1'b1 || dout_b !== 32'hAA22CC44 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL be_lat2: b=%h/%b a_valid=%b, required AA22CC44/1 0", dout_b, valid_b,
               valid_a);
    end
    n_tests++;
    if (dout_a !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL dout_hold: got %h, required AA22CC44", dout_a);
    end
    tick();
  endtask

  task automatic test_rdw();
    do_write(4'd5, 32'hDEADBEEF, 4'b1111);
    we = 1'b1; wr_addr = 4'd5; wr_din = 32'h12345678; wr_be = 4'b1111;
    re = 1'b1; rd_addr = 4'd5;
    tick();
    we = 1'b1; wr_addr = 4'd6; wr_din = 32'hCAFEF00D; wr_be = 4'b0011;
    n_tests++;
    if (dout_a !== 32'hDEADBEEF || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_read_first: got %h/%b, required DEADBEEF/1", dout_a, valid_a);
    end
    tick();
    we = 1'b0; re = 1'b0;
    n_tests++;
    if (dout_b !== 32'h12345678 || valid_b !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_write_first: got %h/%b, required 12345678/1", dout_b, valid_b);
    end
    n_tests++;
    if (dout_a !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rdw_other_addr_a: got %h, required 12345678", dout_a);
    end
    tick();
    n_tests++;
    if (dout_b !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rdw_other_addr_b: got %h, required 12345678", dout_b);
    end
    exp_a[5] = 32'h12345678; exp_c[5] = 32'h12345678;
    exp_a[6] = 32'h0000F00D; exp_c[6] = 32'h0000F00D;
    tick();
  endtask

  task automatic test_out_of_range();
    do_write(4'd13, 32'hFFFFFFFF, 4'b1111);
    exp_a[13] = 32'hFFFFFFFF;
    re = 1'b1; rd_addr = 4'd13;
    tick();
    n_tests++;
    if (dout_c !== 32'h0 || valid_c !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_read_c: got %h/%b, required 00000000/1", dout_c, valid_c);
    end
    n_tests++;
    if (dout_a !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL inrange_13_a: got %h, required FFFFFFFF", dout_a);
    end
    for (int i = 0; i < 12; i++) begin
      rd_addr = 4'(i);
      tick();
      n_tests++;
      if (dout_c !== exp_c[i] || valid_c !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_c[%0d]: got %h/%b, required %h/1", i, dout_c, valid_c, exp_c[i]);
      end
      n_tests++;
      if (dout_a !== exp_a[i]) begin
        n_fail++;
        $display("FAIL b2b_a[%0d]: got %h, required %h", i, dout_a, exp_a[i]);
      end
      if (i > 0) begin
        n_tests++;
        if (dout_b !== exp_a[i-1] || valid_b !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_b[%0d]: got %h/%b, required %h/1", i - 1, dout_b, valid_b,
                   exp_a[i-1]);
        end
      end
    end
    re = 1'b0;
    tick();
    n_tests++;
    if (dout_b !== exp_a[11] || valid_b !== 1'b1 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: b=%h/%b a_valid=%b, required %h/1 0", dout_b, valid_b, valid_a,
               exp_a[11]);
    end
    tick();
  endtask

  task automatic test_clear_drop();
    int done_n = 0;
    for (int i = 0; i < 16; i++) do_write(4'(i), {4{8'(i + 1)}}, 4'b1111);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    we = 1'b1; wr_addr = 4'd0; wr_din = 32'hAAAAAAAA; wr_be = 4'b1111;
    re = 1'b1; rd_addr = 4'd1;
    tick();
    we = 1'b0; re = 1'b0;
    n_tests++;
    if (drop_a !== 1'b1 || drop_c !== 1'b1 || valid_a !== 1'b0 || valid_c !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: drop=%b%b valid=%b%b, required 11 00", drop_a, drop_c,
               valid_a, valid_c);
    end
    tick();
    n_tests++;
    if (drop_a !== 1'b0 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_end: drop=%b b_valid=%b, required 0 0", drop_a, valid_b);
    end
    for (int i = 0; i < 20; i++) begin
      if (done_a) done_n++;
      tick();
    end
    n_tests++;
    if (done_n != 1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_req_done: done=%0d busy=%b, required 1 0", done_n, busy_a);
    end
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; rd_addr = 4'(i);
      tick();
      n_tests++;
      if (dout_a !== 32'h0 || (i < 12 && dout_c !== 32'h0)) begin
        n_fail++;
        $display("FAIL cleared_after_req[%0d]: a=%h c=%h, required 0", i, dout_a, dout_c);
      end
    end
    re = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int busy_n = 0;
    do_write(4'd15, 32'h77777777, 4'b1111);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b done=%b, required 1 0", busy_a, done_a);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (busy_a) busy_n++;
      tick();
    end
    n_tests++;
    if (busy_n != 16) begin
      n_fail++;
      $display("FAIL restart_len: busy=%0d, required 16", busy_n);
    end
    re = 1'b1; rd_addr = 4'd15;
    tick();
    re = 1'b0;
    n_tests++;
    if (dout_a !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_cleared15: got %h, required 00000000", dout_a);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    int vld_n = 0;
    do_write(4'd3, 32'h5A5A5A5A, 4'b1111);
    re = 1'b1; rd_addr = 4'd3;
    tick();
    re = 1'b0;
    n_tests++;
    if (dout_a !== 32'h5A5A5A5A || valid_a !== 1'b1 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_pre: a=%h/%b b_valid=%b, required 5A5A5A5A/1 0", dout_a,
               valid_a, valid_b);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dout_a !== 32'h0 || valid_a !== 1'b0 || dout_b !== 32'h0 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_async: a=%h/%b b=%h/%b, required 0/0", dout_a, valid_a, dout_b,
               valid_b);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (valid_b) vld_n++;
      tick();
    end
    n_tests++;
    if (vld_n != 0 || dout_b !== 32'h0) begin
      n_fail++;
      $display("FAIL inflight_discard: valids=%0d dout=%h, required 0 00000000", vld_n, dout_b);
    end
  endtask

  initial begin
    we = 1'b0; re = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_din = '0;
    for (int i = 0; i < 16; i++) exp_a[i] = '0;
    for (int i = 0; i < 12; i++) exp_c[i] = '0;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_clear_drop();
    test_reset_mid_clear();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
Parametrised simple dual-port RAM, next generation of the team's single-clock RAM. Adds per-byte write enables, selectable read latency (1 or 2), selectable read-during-write behaviour, out-of-range protection, and a sequential clear engine with a busy/done handshake. The clear engine replaces the parallel array reset, so the array maps to block RAM. Used as the generic storage primitive under FIFOs, register files and buffers.

Parameters:
ADDR_WIDTH, 4, address width of both ports
DATA_WIDTH, 32, word width; must be a multiple of 8
DEPTH, 16, number of words; must be <= 2**ADDR_WIDTH
RD_LATENCY, 1, re to rd_dout/rd_valid latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read and write in one cycle: 0 = old data (read-first), 1 = new merged data (write-first)
CLR_ON_RESET, 1, 1 = clear engine starts automatically when reset deasserts

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/8  byte enables; bit i selects byte [8i+7:8i]
wr_din  in  DATA_WIDTH  write data
re  in  1  read enable
rd_addr  in  ADDR_WIDTH  read address
rd_dout  out  DATA_WIDTH  read data
rd_valid  out  1  1-cycle pulse, rd_dout holds a new read result
clr_req  in  1  request a full-array clear (level, sampled in IDLE)
clr_busy  out  1  clear in progress; array access blocked
clr_done  out  1  1-cycle pulse when the clear completes
acc_drop  out  1  1-cycle pulse when a we or re was dropped because clr_busy was high

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_dout=0, rd_valid=0; read pipeline cleared; clr_done=0; acc_drop=0; clear pointer=0.
  - FSM goes to CLEAR if CLR_ON_RESET=1, else IDLE. clr_busy resets to CLR_ON_RESET.
  - Array contents are not reset directly.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR on the next cycle. The pointer is set to 0 and clr_busy=1 from that cycle.
  - CLEAR: each cycle writes mem[ptr]=0 and increments ptr. After writing ptr==DEPTH-1, go to DONE. Duration is exactly DEPTH cycles.
  - DONE: clr_busy=0 and clr_done=1 for one cycle, then IDLE. clr_req is ignored in CLEAR and DONE.
  - Asserting rst_n=0 mid-clear aborts the clear. If CLR_ON_RESET=1, the clear restarts from 0 after reset.
- Access while clr_busy=1: we and re are ignored, with no rd_valid. acc_drop pulses in the cycle after any dropped request.
- Write:
  - we=1 and wr_addr<DEPTH: bytes with wr_be[i]=1 are updated at the clock edge; other bytes are unchanged.
  - wr_be=0 is a no-op.
  - wr_addr>=DEPTH: write is ignored.
- Read:
  - re=1: the result appears on rd_dout with rd_valid=1 exactly RD_LATENCY cycles after the re cycle.
  - rd_dout holds its last value when there is no new result.
  - rd_addr>=DEPTH returns 0 with rd_valid=1.
  - Back-to-back reads give one result per cycle in order.
- Read-during-write (same cycle, rd_addr==wr_addr, both in range):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the old word with the enabled bytes replaced by wr_din.
- Writes to different addresses in the same cycle as a read do not interact.
- Reset during an in-flight read: the result is discarded and rd_valid stays 0.
- Elaboration checks: DATA_WIDTH%8==0, DEPTH<=2**ADDR_WIDTH, RD_LATENCY in {1,2}. Failure is a fatal error.

Decomposition:
- Package ram_pkg:
  - rdw_mode_e enum (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1)
  - clr_state_e enum (IDLE, CLEAR, DONE)
  - default width/depth constants
  - byte-width constant BYTE_W=8
- One sub-module, ram_clr_fsm: the state register, pointer, clr_busy, clr_done, and the clear write-port signals.
- Top level owns the array, byte-enable merge, RDW mux and read pipeline.

Test Plan (DATA_WIDTH=32, DEPTH=16, ADDR_WIDTH=4 unless noted):
1. Reset release with CLR_ON_RESET=1 -> clr_busy=1 for 16 cycles, then clr_done pulses once. Reads of all 16 addresses then return 0x00000000.
2. Write 0xAABBCCDD to addr 3 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101 -> read of addr 3 returns 0xAA22CC44. rd_valid arrives 1 cycle after re for RD_LATENCY=1 and 2 cycles after for RD_LATENCY=2.
3. Same-cycle write 0x12345678 (wr_be=4'b1111) and read of addr 5, where mem[5]=0xDEADBEEF -> RDW_MODE=0 returns 0xDEADBEEF; RDW_MODE=1 returns 0x12345678.
4. DEPTH=12: write 0xFFFFFFFF to addr 13, then read addr 13 -> rd_dout=0 with rd_valid=1. Addresses 0-11 are unchanged.
5. clr_req after filling the array; issue we/re on the 4th busy cycle -> acc_drop pulses once, with no rd_valid. The array is all zero after clr_done.
6. rst_n low on clear cycle 7, and separately during an in-flight read with RD_LATENCY=2 -> clear restarts from ptr 0 (16 busy cycles). The in-flight read produces no rd_valid and rd_dout=0.
